mc_muldiv_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO registers for the MIPS datapath, extending R-type decode beyond add/sub/and/or to mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It accepts one R-type operation at a time from the controller via a start/ready handshake and computes products and quotients with a radix-2 shift-add or restoring sequence. It reports completion, divide-by-zero and undefined funct codes as single-cycle pulses.

---
 rtl/mc_muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_mc_muldiv_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_muldiv_unit.sv
// mc_muldiv_unit
// Iterative multiply/divide unit holding the MIPS HI/LO registers.
// One R-type operation is accepted at a time on start && ready. MULT/MULTU
// use a radix-2 shift-add sequence and DIV/DIVU use restoring division.
// Each takes WIDTH RUN cycles plus one FIX cycle for sign correction.
// MTHI/MTLO/MFHI/MFLO, divide-by-zero and undefined functs finish in a
// single cycle.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start, funct    request strobe and R-type funct code
//   op_a, op_b      rs / rt operand values
//   ready           unit is idle and will accept start
//   done            one-cycle pulse: hi/lo hold the result
//   hi, lo          HI / LO architectural registers
//   div_by_zero     one-cycle pulse with done for DIV/DIVU by zero
//   undefined_instr one-cycle pulse for an unsupported funct
module mc_muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             undefined_instr
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;      // multiply: {P_hi, P_lo}; divide: {rem, quo}
    logic [WIDTH-1:0]   divisor;  // |op_b|, used as multiplicand or divisor
    logic               is_div;
    logic               sign_a;
    logic               sign_b;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               xz_guard;

    assign ready = (state == IDLE);

    // MULT (0x18) and DIV (0x1A) are the signed forms.
    assign signed_op = ~funct[0];
    assign abs_a     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    // Add the multiplicand into the upper half when the current multiplier
    // bit is set. The extra bit keeps the carry, which the right shift
    // then moves into the top of the accumulator.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);

    // Trial subtract on the left-shifted remainder. It is WIDTH+1 bits wide
    // because the shifted remainder can exceed WIDTH bits for large
    // unsigned divisors. Bit WIDTH set means a borrow.
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, divisor};

    assign prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
    assign quo_fix   = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // Zero in hardware. In 4-state simulation it is X when funct carries
    // X/Z, so an unknown funct never raises undefined_instr.
    assign xz_guard  = ^funct ^ ^funct;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            divisor         <= '0;
            is_div          <= 1'b0;
            sign_a          <= 1'b0;
            sign_b          <= 1'b0;
            hi              <= '0;
            lo              <= '0;
            done            <= 1'b0;
            div_by_zero     <= 1'b0;
            undefined_instr <= 1'b0;
        end else begin
            done            <= 1'b0;
            div_by_zero     <= 1'b0;
            undefined_instr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (funct)
                            F_MFHI, F_MFLO: done <= 1'b1;
                            F_MTHI: begin
                                hi   <= op_a;
                                done <= 1'b1;
                            end
                            F_MTLO: begin
                                lo   <= op_a;
                                done <= 1'b1;
                            end
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                if (funct[1] && op_b == '0) begin
                                    hi          <= op_a;
                                    lo          <= '1;
                                    done        <= 1'b1;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    state   <= RUN;
                                    cnt     <= '0;
                                    acc     <= {{WIDTH{1'b0}}, abs_a};
                                    divisor <= abs_b;
                                    is_div  <= funct[1];
                                    sign_a  <= signed_op & op_a[WIDTH-1];
                                    sign_b  <= signed_op & op_b[WIDTH-1];
                                end
                            end
                            default: begin
                                if (!xz_guard)
                                    undefined_instr <= 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIX;
                    if (is_div) begin
                        if (!div_trial[WIDTH])
                            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_muldiv_unit.sv
// Self-checking bench for mc_muldiv_unit (WIDTH=32).
// A cycle-level reference model computes results with plain arithmetic.
// A negedge compare process checks every DUT output against that model on
// every cycle. Directed cases pin literal results and latencies, and a
// randomized phase follows them.
module tb_mc_muldiv_unit;

    localparam int W = 32;
    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] op_a, op_b;
    logic         ready, done, div_by_zero, undefined_instr;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mc_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .op_a(op_a), .op_b(op_b), .ready(ready), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
        .undefined_instr(undefined_instr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_busy = 0;   // edges left until the multicycle result lands
    logic         m_done = 1'b0, m_dbz = 1'b0, m_undef = 1'b0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0;
            m_done = 1'b0; m_dbz = 1'b0; m_undef = 1'b0;
        end else begin
            m_done = 1'b0; m_dbz = 1'b0; m_undef = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (start) begin
                model_accept();
            end
        end
    end

    task automatic model_accept();
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa, sb;
        case (funct)
            MFHI, MFLO: m_done = 1'b1;
            MTHI: begin m_hi = op_a; m_done = 1'b1; end
            MTLO: begin m_lo = op_a; m_done = 1'b1; end
            MULT: begin
                sp = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
                p_hi = sp[63:32]; p_lo = sp[31:0]; m_busy = W + 1;
            end
            MULTU: begin
                up = {32'b0, op_a} * {32'b0, op_b};
                p_hi = up[63:32]; p_lo = up[31:0]; m_busy = W + 1;
            end
            DIV, DIVU: begin
                if (op_b == 0) begin
                    m_hi = op_a; m_lo = '1; m_done = 1'b1; m_dbz = 1'b1;
                end else begin
                    if (funct == DIVU) begin
                        p_lo = op_a / op_b; p_hi = op_a % op_b;
                    end else if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                        p_lo = 32'h8000_0000; p_hi = '0;
                    end else begin
                        sa = op_a; sb = op_b;
                        p_lo = sa / sb; p_hi = sa % sb;
                    end
                    m_busy = W + 1;
                end
            end
            default: m_undef = 1'b1;
        endcase
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({ready, done, div_by_zero, undefined_instr, hi, lo} !==
                {(m_busy == 0), m_done, m_dbz, m_undef, m_hi, m_lo}) begin
                errors++;
                $display("FAIL cycle_compare t=%0t: got rdy=%b done=%b dbz=%b und=%b hi=%h lo=%h want rdy=%b done=%b dbz=%b und=%b hi=%h lo=%h",
                         $time, ready, done, div_by_zero, undefined_instr, hi, lo,
                         (m_busy == 0), m_done, m_dbz, m_undef, m_hi, m_lo);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Caller is at a negedge; the start is accepted at the next rising edge.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; funct = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'($urandom); op_a = $urandom; op_b = $urandom;
    endtask

    // Returns at the negedge where done or undefined_instr is high.
    // n counts negedges after the accept edge; rl counts cycles with ready low.
    task automatic wait_pulse(output int n, output int rl);
        n = 0; rl = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ready) rl++;
        end while (!(done || undefined_instr) && n < 60);
        if (n >= 60) begin
            checks++; errors++;
            $display("FAIL wait_pulse: got no pulse within %0d cycles want pulse", n);
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, rl, c;
        logic [5:0] f;
        logic [W-1:0] a, b;
        start = 1'b0; funct = '0; op_a = '0; op_b = '0; reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_ctrl", {ready, done, div_by_zero, undefined_instr}, 4'b1000);
        chk("reset_hilo", {hi, lo}, 64'h0);
        @(posedge clk); #1 reset = 1'b0;

        // MULTU max x max: latency and ready-low length
        @(negedge clk);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_pulse(n, rl);
        chk("multu_latency", n - 1, 33);
        chk("multu_ready_low", rl, 33);
        chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        chk("multu_ready_in_done", ready, 1);
        @(negedge clk);
        chk("multu_done_one_cycle", done, 0);

        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        wait_pulse(n, rl);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        @(negedge clk);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_pulse(n, rl);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        @(negedge clk);
        issue(DIVU, 32'd7, 32'd2);
        wait_pulse(n, rl);
        chk("divu", {hi, lo}, 64'h0000_0001_0000_0003);

        @(negedge clk);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_pulse(n, rl);
        chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

        @(negedge clk);
        issue(DIV, 32'h1234, 32'd0);
        wait_pulse(n, rl);
        chk("dbz_latency", n, 1);
        chk("dbz_flags", {done, div_by_zero, ready}, 3'b111);
        chk("dbz_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        chk("dbz_ready_never_low", rl, 0);

        @(negedge clk);
        issue(MTHI, 32'hA5A5_A5A5, 32'd0);
        wait_pulse(n, rl);
        chk("mthi", {n, hi}, {32'd1, 32'hA5A5_A5A5});
        @(negedge clk);
        issue(MTLO, 32'h5A5A_5A5A, 32'd0);
        wait_pulse(n, rl);
        chk("mtlo", {n, lo}, {32'd1, 32'h5A5A_5A5A});
        @(negedge clk);
        issue(MFHI, 32'd0, 32'd0);
        wait_pulse(n, rl);
        chk("mfhi", {done, hi, lo}, {1'b1, 64'hA5A5_A5A5_5A5A_5A5A});

        @(negedge clk);
        issue(6'h3F, 32'h1111_1111, 32'h2222_2222);
        wait_pulse(n, rl);
        chk("undef_pulse", {n[7:0], undefined_instr, done, ready}, {8'd1, 3'b101});
        chk("undef_hilo", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);
        @(negedge clk);
        chk("undef_one_cycle", undefined_instr, 0);

        // second start mid-MULT is dropped
        issue(MULT, 32'd100, 32'hFFFF_FFFD);
        repeat (4) @(posedge clk);
        #1; start = 1'b1; funct = DIVU; op_a = 32'd50; op_b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        wait_pulse(n, rl);
        chk("drop_latency", n - 1, 28);
        chk("drop_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FED4);
        count_done(40, c);
        chk("drop_no_extra_done", c, 0);

        // reset mid-DIV
        @(negedge clk);
        issue(DIV, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_run", {ready, done, hi, lo}, {2'b10, 64'h0});
        @(posedge clk); #1 reset = 1'b0;
        count_done(40, c);
        chk("reset_no_done", c, 0);

        // back-to-back MULTU
        @(negedge clk);
        issue(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_pulse(n, rl);
        issue(MULTU, 32'd3, 32'd5);
        wait_pulse(n, rl);
        chk("b2b_latency", n - 1, 33);
        chk("b2b_hilo", {hi, lo}, 64'h0000_0000_0000_000F);

        // randomized phase; the per-cycle compare does the checking
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: b = $urandom_range(0, 9);
                2: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            case ($urandom_range(0, 9))
                0: f = MFHI;  1: f = MTHI;  2: f = MFLO;  3: f = MTLO;
                4: f = MULT;  5: f = MULTU; 6: f = DIV;   7: f = DIVU;
                8: begin
                    f = 6'h3F;
                    for (int k = 0; k < 8; k++) begin
                        f = 6'($urandom);
                        if (!(f inside {[6'h10:6'h13], [6'h18:6'h1B]})) break;
                    end
                    if (f inside {[6'h10:6'h13], [6'h18:6'h1B]}) f = 6'h00;
                end
                default: begin f = ($urandom_range(0, 1) != 0) ? DIV : DIVU; b = '0; end
            endcase
            issue(f, a, b);
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (m_busy == 0) break;
                if ($urandom_range(0, 7) == 0) begin
                    start = 1'b1; funct = 6'($urandom); op_a = $urandom; op_b = $urandom;
                    @(posedge clk); #1 start = 1'b0;
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
